// File: rtl/instr_encoder.sv
// ============================================================================
//  Module      : instr_encoder
//  Description : Streaming RV32I instruction encoder. Packs decoded fields
//                (opcode, funct3, rd, rs1, rs2, 32-bit immediate, format)
//                into a 32-bit instruction word paired with a sequential
//                instruction-memory address. Two-stage valid/ready pipeline
//                with full throughput.
//  Optional    : INSTR_ENC_ERR_DROP_EN - when defined, requests whose
//                immediate is out of range/misaligned are dropped between
//                stage 1 and stage 2 (no word, no address consumed, error
//                still counted); out_err is then always 0.
//  Ports       : clk, reset_n (async, active low), clear (sync flush)
//                in_valid/in_ready, in_type, in_opcode, in_funct3, in_rd,
//                in_rs1, in_rs2, in_imm                   - request side
//                out_valid/out_ready, out_instr, out_addr, out_err - output
//                err_count                               - saturating errors
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_type,
    input  logic [6:0]           in_opcode,
    input  logic [2:0]           in_funct3,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic [31:0]          out_addr,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [1:0] c_FMT_I = 2'b00;
    localparam logic [1:0] c_FMT_S = 2'b01;
    localparam logic [1:0] c_FMT_B = 2'b10;
    localparam logic [1:0] c_FMT_J = 2'b11;

    // Stage 1 registers. Only imm[20:0] is kept: the range check is done on
    // the full input, and no format uses bits above 20 for the encoding.
    logic        r_s1_valid;
    logic [1:0]  r_s1_type;
    logic [6:0]  r_s1_opcode;
    logic [2:0]  r_s1_funct3;
    logic [4:0]  r_s1_rd;
    logic [4:0]  r_s1_rs1;
    logic [4:0]  r_s1_rs2;
    logic [20:0] r_s1_imm;
    logic        r_s1_err;

    // Stage 2 / output registers
    logic                 r_out_valid;
    logic [31:0]          r_out_instr;
    logic [31:0]          r_out_addr;
    logic                 r_out_err;
    logic [31:0]          r_addr_cnt;
    logic [ERR_CNT_W-1:0] r_err_count;

    logic        w_adv2;
    logic        w_accept;
    logic        w_load2;
    logic        w_err_evt;
    logic        w_range_err;
    logic        w_ext_i;
    logic        w_ext_b;
    logic        w_ext_j;
    logic [31:0] w_enc;

    // Stage 2 can take a new word when it is empty or its word leaves now.
    assign w_adv2   = ~r_out_valid | out_ready;
    assign in_ready = ~clear & (~r_s1_valid | w_adv2);
    assign w_accept = in_valid & in_ready;

    // An immediate fits in N+1 signed bits when bits [31:N] are all equal.
    assign w_ext_i = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign w_ext_b = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign w_ext_j = (&in_imm[31:20]) | ~(|in_imm[31:20]);

    always_comb begin
        w_range_err = 1'b0;
        case (in_type)
            c_FMT_I, c_FMT_S: w_range_err = ~w_ext_i;
            c_FMT_B:          w_range_err = ~w_ext_b | in_imm[0];
            default:          w_range_err = ~w_ext_j | in_imm[0];
        endcase
    end

    // Encoding from stage-1 contents; out-of-range values use truncated bits.
    always_comb begin
        w_enc = 32'h0;
        case (r_s1_type)
            c_FMT_I: w_enc = {r_s1_imm[11:0], r_s1_rs1, r_s1_funct3,
                              r_s1_rd, r_s1_opcode};
            c_FMT_S: w_enc = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_funct3,
                              r_s1_imm[4:0], r_s1_opcode};
            c_FMT_B: w_enc = {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1,
                              r_s1_funct3, r_s1_imm[4:1], r_s1_imm[11],
                              r_s1_opcode};
            c_FMT_J: w_enc = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11],
                              r_s1_imm[19:12], r_s1_rd, r_s1_opcode};
            default: w_enc = 32'h0;
        endcase
    end

    // An errored stage-1 word still counts as an error event whether or not
    // it is forwarded to stage 2.
    assign w_err_evt = w_adv2 & r_s1_valid & r_s1_err;
`ifdef INSTR_ENC_ERR_DROP_EN
    assign w_load2 = w_adv2 & r_s1_valid & ~r_s1_err;
`else
    assign w_load2 = w_adv2 & r_s1_valid;
`endif

    // Stage 1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_type   <= 2'b00;
            r_s1_opcode <= 7'h0;
            r_s1_funct3 <= 3'h0;
            r_s1_rd     <= 5'h0;
            r_s1_rs1    <= 5'h0;
            r_s1_rs2    <= 5'h0;
            r_s1_imm    <= 21'h0;
            r_s1_err    <= 1'b0;
        end else if (clear) begin
            r_s1_valid <= 1'b0;
        end else begin
            // in_ready implies stage 1 is empty or draining this cycle.
            if (in_ready) begin
                r_s1_valid <= in_valid;
            end
            if (w_accept) begin
                r_s1_type   <= in_type;
                r_s1_opcode <= in_opcode;
                r_s1_funct3 <= in_funct3;
                r_s1_rd     <= in_rd;
                r_s1_rs1    <= in_rs1;
                r_s1_rs2    <= in_rs2;
                r_s1_imm    <= in_imm[20:0];
                r_s1_err    <= w_range_err;
            end
        end
    end

    // Stage 2, address counter and error counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_instr <= 32'h0;
            r_out_addr  <= BASE_ADDR;
            r_out_err   <= 1'b0;
            r_addr_cnt  <= BASE_ADDR;
            r_err_count <= '0;
        end else if (clear) begin
            r_out_valid <= 1'b0;
            r_addr_cnt  <= BASE_ADDR;
        end else begin
            if (w_adv2) begin
                r_out_valid <= w_load2;
            end
            if (w_load2) begin
                r_out_instr <= w_enc;
                r_out_err   <= r_s1_err;
                r_out_addr  <= r_addr_cnt;
                r_addr_cnt  <= r_addr_cnt + 32'd4;
            end
            if (w_err_evt && (r_err_count != {ERR_CNT_W{1'b1}})) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_addr  = r_out_addr;
    assign err_count = r_err_count;
`ifdef INSTR_ENC_ERR_DROP_EN
    assign out_err = 1'b0;
`else
    assign out_err = r_out_err;
`endif

endmodule

`default_nettype wire
